// File: rtl/tdm_demux_1to8_if.sv
// Bundle for the 1:8 TDM demultiplexer: sample stream in, per-slot/frame outputs,
// frame handshake and overrun control.
interface tdm_demux_1to8_if #(
  parameter int DW = 1
);
  logic [DW-1:0]   din;
  logic            din_vld;
  logic            sof;
  logic [8*DW-1:0] y;
  logic [7:0]      strb;
  logic [8*DW-1:0] frame;
  logic            frame_vld;
  logic            frame_rdy;
  logic            sync_err;
  logic            ovr;
  logic            ovr_clr;

  modport master (
    output din, din_vld, sof, frame_rdy, ovr_clr,
    input  y, strb, frame, frame_vld, sync_err, ovr
  );

  modport slave (
    input  din, din_vld, sof, frame_rdy, ovr_clr,
    output y, strb, frame, frame_vld, sync_err, ovr
  );
endinterface

// File: rtl/tdm_demux_1to8.sv
// 1:8 time-division demultiplexer: tracks slot position from sof, fans samples out
// to per-slot registers and hands completed frames to a valid/ready consumer.
module tdm_demux_1to8 #(
  parameter int DW = 1
) (
  input logic             clk,
  input logic             rst_n,
  tdm_demux_1to8_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [8*DW-1:0] y_q, y_d;
  logic [7:0]      strb_q, strb_d;
  logic [8*DW-1:0] frame_q, frame_d;
  logic            frame_vld_q, frame_vld_d;
  logic            sync_err_q, sync_err_d;
  logic            ovr_q, ovr_d;

  logic            acc;
  logic [2:0]      acc_slot;
  logic            resync;
  logic            complete;
  logic            ovr_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      y_q         <= '0;
      strb_q      <= '0;
      frame_q     <= '0;
      frame_vld_q <= 1'b0;
      sync_err_q  <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      strb_q      <= strb_d;
      frame_q     <= frame_d;
      frame_vld_q <= frame_vld_d;
      sync_err_q  <= sync_err_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc      = 1'b0;
    acc_slot = cnt_q;
    resync   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.din_vld && bus.sof) begin
          acc      = 1'b1;
          acc_slot = 3'd0;
          cnt_d    = 3'd1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (bus.din_vld) begin
          acc = 1'b1;
          if (bus.sof) begin
            acc_slot = 3'd0;
            cnt_d    = 3'd1;
            resync   = (cnt_q != 3'd0);
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slots 0..6 of y are all from the current frame whenever slot 7 is accepted,
  // so the completed frame is assembled straight from y plus the incoming sample.
  always_comb begin
    y_d         = y_q;
    strb_d      = '0;
    frame_d     = frame_q;
    frame_vld_d = frame_vld_q;
    sync_err_d  = resync;
    ovr_set     = 1'b0;
    complete    = acc && (acc_slot == 3'd7);

    for (int unsigned k = 0; k < 8; k++) begin
      if (acc && (32'(acc_slot) == k)) begin
        y_d[k*DW +: DW] = bus.din;
        strb_d[k]       = 1'b1;
      end
    end

    if (complete) begin
      if (!frame_vld_q || bus.frame_rdy) begin
        frame_d     = {bus.din, y_q[7*DW-1:0]};
        frame_vld_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (frame_vld_q && bus.frame_rdy) begin
      frame_vld_d = 1'b0;
    end

    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (bus.ovr_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  assign bus.y         = y_q;
  assign bus.strb      = strb_q;
  assign bus.frame     = frame_q;
  assign bus.frame_vld = frame_vld_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.ovr       = ovr_q;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Directed bench for tdm_demux_1to8 (DW=1): vector table plus hand-written
// reset sequences.
module tb_tdm_demux_1to8;

  logic clk;
  logic rst_n;

  tdm_demux_1to8_if #(.DW(1)) bus ();

  tdm_demux_1to8 #(.DW(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       din;
    logic       vld;
    logic       sof;
    logic       rdy;
    logic       clr;
    logic [7:0] strb;
    logic [7:0] y;
    logic [7:0] frame;
    logic       fv;
    logic       serr;
    logic       ovr;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(logic din, logic vld, logic sof, logic rdy, logic clr,
                              logic [7:0] strb, logic [7:0] y, logic [7:0] frame,
                              logic fv, logic serr, logic ovr);
    vec_t v;
    v.din = din; v.vld = vld; v.sof = sof; v.rdy = rdy; v.clr = clr;
    v.strb = strb; v.y = y; v.frame = frame; v.fv = fv; v.serr = serr; v.ovr = ovr;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%02h expected 0x%02h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [7:0] strb, input logic [7:0] y,
                         input logic [7:0] frame, input logic fv, input logic serr,
                         input logic ovr);
    chk("strb",      idx, bus.strb,            strb);
    chk("y",         idx, bus.y,               y);
    chk("frame",     idx, bus.frame,           frame);
    chk("frame_vld", idx, {7'd0, bus.frame_vld}, {7'd0, fv});
    chk("sync_err",  idx, {7'd0, bus.sync_err},  {7'd0, serr});
    chk("ovr",       idx, {7'd0, bus.ovr},       {7'd0, ovr});
  endtask

  task automatic drive(input logic din, input logic vld, input logic sof,
                       input logic rdy, input logic clr);
    bus.din = din; bus.din_vld = vld; bus.sof = sof;
    bus.frame_rdy = rdy; bus.ovr_clr = clr;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;

    // samples before any sof are ignored; sof without din_vld does nothing
    add(1,1,0,0,0, 8'h00,8'h00,8'h00,0,0,0);
    add(1,1,0,0,0, 8'h00,8'h00,8'h00,0,0,0);
    add(0,1,0,0,0, 8'h00,8'h00,8'h00,0,0,0);
    add(1,0,1,0,0, 8'h00,8'h00,8'h00,0,0,0);
    // frame 1: 1,0,1,1,0,0,1,0
    add(1,1,1,0,0, 8'h01,8'h01,8'h00,0,0,0);
    add(0,1,0,0,0, 8'h02,8'h01,8'h00,0,0,0);
    add(1,1,0,0,0, 8'h04,8'h05,8'h00,0,0,0);
    add(1,1,0,0,0, 8'h08,8'h0D,8'h00,0,0,0);
    add(0,1,0,0,0, 8'h10,8'h0D,8'h00,0,0,0);
    add(0,1,0,0,0, 8'h20,8'h0D,8'h00,0,0,0);
    add(1,1,0,0,0, 8'h40,8'h4D,8'h00,0,0,0);
    add(0,1,0,0,0, 8'h80,8'h4D,8'h4D,1,0,0);
    // consume frame 1; sof without valid in RUN
    add(0,0,0,1,0, 8'h00,8'h4D,8'h4D,0,0,0);
    add(1,0,1,0,0, 8'h00,8'h4D,8'h4D,0,0,0);
    // partial frame of 4 slots, then out-of-place sof
    add(0,1,1,0,0, 8'h01,8'h4C,8'h4D,0,0,0);
    add(1,1,0,0,0, 8'h02,8'h4E,8'h4D,0,0,0);
    add(1,1,0,0,0, 8'h04,8'h4E,8'h4D,0,0,0);
    add(1,1,0,0,0, 8'h08,8'h4E,8'h4D,0,0,0);
    add(1,1,1,0,0, 8'h01,8'h4F,8'h4D,0,1,0);
    add(0,1,0,0,0, 8'h02,8'h4D,8'h4D,0,0,0);
    add(0,1,0,0,0, 8'h04,8'h49,8'h4D,0,0,0);
    add(0,1,0,0,0, 8'h08,8'h41,8'h4D,0,0,0);
    add(0,1,0,0,0, 8'h10,8'h41,8'h4D,0,0,0);
    add(0,1,0,0,0, 8'h20,8'h41,8'h4D,0,0,0);
    add(0,1,0,0,0, 8'h40,8'h01,8'h4D,0,0,0);
    add(0,1,0,0,0, 8'h80,8'h01,8'h01,1,0,0);
    // frame 3 all ones; consumer ready exactly on slot 7 while frame 2 pending
    add(1,1,1,0,0, 8'h01,8'h01,8'h01,1,0,0);
    add(1,1,0,0,0, 8'h02,8'h03,8'h01,1,0,0);
    add(1,1,0,0,0, 8'h04,8'h07,8'h01,1,0,0);
    add(1,1,0,0,0, 8'h08,8'h0F,8'h01,1,0,0);
    add(1,1,0,0,0, 8'h10,8'h1F,8'h01,1,0,0);
    add(1,1,0,0,0, 8'h20,8'h3F,8'h01,1,0,0);
    add(1,1,0,0,0, 8'h40,8'h7F,8'h01,1,0,0);
    add(1,1,0,1,0, 8'h80,8'hFF,8'hFF,1,0,0);
    // frame 4 via counter wrap (no sof), not consumed -> overrun
    add(0,1,0,0,0, 8'h01,8'hFE,8'hFF,1,0,0);
    add(0,1,0,0,0, 8'h02,8'hFC,8'hFF,1,0,0);
    add(0,1,0,0,0, 8'h04,8'hF8,8'hFF,1,0,0);
    add(0,1,0,0,0, 8'h08,8'hF0,8'hFF,1,0,0);
    add(0,1,0,0,0, 8'h10,8'hE0,8'hFF,1,0,0);
    add(0,1,0,0,0, 8'h20,8'hC0,8'hFF,1,0,0);
    add(0,1,0,0,0, 8'h40,8'h80,8'hFF,1,0,0);
    add(0,1,0,0,0, 8'h80,8'h00,8'hFF,1,0,1);
    add(0,0,0,0,0, 8'h00,8'h00,8'hFF,1,0,1);
    add(0,0,0,0,1, 8'h00,8'h00,8'hFF,1,0,0);
    add(0,0,0,1,0, 8'h00,8'h00,8'hFF,0,0,0);

    // reset state
    #12;
    chk_all(-1, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].din, vq[i].vld, vq[i].sof, vq[i].rdy, vq[i].clr);
      @(posedge clk);
      #1;
      chk_all(i, vq[i].strb, vq[i].y, vq[i].frame, vq[i].fv, vq[i].serr, vq[i].ovr);
    end

    // mid-frame asynchronous reset after slot 4
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      drive(1, 1, (s == 0), 0, 0);
      @(posedge clk);
    end
    #1;
    chk_all(100, 8'h10, 8'h1F, 8'hFF, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(101, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // after release, samples without sof are ignored
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      drive(1, 1, 0, 0, 0);
      @(posedge clk);
      #1;
      chk_all(102 + s, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    end
    @(negedge clk);
    drive(1, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    chk_all(110, 8'h01, 8'h01, 8'h00, 0, 0, 0);

    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
